serializador_8bits: RTL and testbench

// Parallel-to-serial reader for the 8-bit register datapath: captures a WIDTH-bit word
// on start and shifts it out one bit per accepted beat over a valid/ready link.

---
 rtl/serializador_8bits.sv | 117 +++++++++++
 tb/tb_serializador_8bits.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_8bits.sv
// -----------------------------------------------------------------------------
// serializador_8bits
// Parallel-to-serial reader. A WIDTH-bit word is captured when start is seen
// in IDLE and is then presented one bit at a time over a valid/ready link.
// The FSM runs IDLE -> SHIFT -> DONE -> IDLE.
//
// Handshake: the serializer presents a bit on sout together with
// sout_valid=1. The bit is consumed on the rising clock edge where both
// sout_valid and sout_ready are 1 (a "beat"). While valid is high and ready is
// low, sout, bit_cnt and the shift register all hold. sout_ready is ignored
// while sout_valid is 0.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active low
//   D           in   parallel word, sampled only when start is accepted
//   start       in   serialize request, accepted only in IDLE
//   sout        out  current serial bit (0 when sout_valid=0)
//   sout_valid  out  sout holds a valid bit
//   sout_ready  in   sink accepts the bit on this edge
//   busy        out  1 while in SHIFT
//   done        out  one-cycle pulse after the last bit is accepted
//   bit_cnt     out  index of the bit currently presented
//   state_dbg   out  FSM state, for observation
// -----------------------------------------------------------------------------
module serializador_8bits #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         D,
   input  logic                     start,
   output logic                     sout,
   output logic                     sout_valid,
   input  logic                     sout_ready,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic [1:0]               state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   // Bit of the shift register that sits at the output end.
   localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q,   cnt_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = D;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // In SHIFT sout_valid is 1, so sout_ready alone marks a beat.
            if (sout_ready) begin
               if (cnt_q == LAST_IDX) begin
                  // Clear the datapath so nothing stale lingers after the word.
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  // Move the next bit toward the output end; vacated bits fill with 0.
                  if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], 1'b0};
                  else           shift_d = {1'b0, shift_q[WIDTH-1:1]};
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode only registered state, so there is no input-to-output path.
   always_comb begin
      sout_valid = (state_q == SHIFT);
      busy       = (state_q == SHIFT);
      done       = (state_q == DONE);
      sout       = (state_q == SHIFT) & shift_q[OUT_IDX];
      bit_cnt    = cnt_q;
      state_dbg  = state_q;
   end

endmodule

// File: tb/tb_serializador_8bits.sv
module tb_serializador_8bits;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] D;
   logic         start;
   logic         sout_ready;

   logic         sout_l, valid_l, busy_l, done_l;
   logic [2:0]   cnt_l;
   logic [1:0]   st_l;
   logic         sout_m, valid_m, busy_m, done_m;
   logic [2:0]   cnt_m;
   logic [1:0]   st_m;

   int checks = 0;
   int passed = 0;

   // Behavioural model: a word in flight plus how many of its bits were taken.
   int           m_phase = 0;  // 0 idle, 1 sending, 2 done cycle
   logic [W-1:0] m_word  = '0;
   int           m_k     = 0;
   logic [W-1:0] exp_q[$];

   // Sink side: words rebuilt from accepted beats.
   logic [W-1:0] rx_l, rx_m;
   int           rx_k = 0;

   always #5 clk = ~clk;

   serializador_8bits #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .D(D), .start(start),
      .sout(sout_l), .sout_valid(valid_l), .sout_ready(sout_ready),
      .busy(busy_l), .done(done_l), .bit_cnt(cnt_l), .state_dbg(st_l)
   );

   serializador_8bits #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .D(D), .start(start),
      .sout(sout_m), .sout_valid(valid_m), .sout_ready(sout_ready),
      .busy(busy_m), .done(done_m), .bit_cnt(cnt_m), .state_dbg(st_m)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Compare every output of both instances against the model.
   task automatic compare_all();
      logic ev;
      ev = (m_phase == 1);
      chk("valid_l", 32'(valid_l), 32'(ev));
      chk("valid_m", 32'(valid_m), 32'(ev));
      chk("busy_l",  32'(busy_l),  32'(ev));
      chk("busy_m",  32'(busy_m),  32'(ev));
      chk("done_l",  32'(done_l),  32'(m_phase == 2));
      chk("done_m",  32'(done_m),  32'(m_phase == 2));
      chk("sout_l",  32'(sout_l),  32'(ev ? m_word[m_k] : 1'b0));
      chk("sout_m",  32'(sout_m),  32'(ev ? m_word[W-1-m_k] : 1'b0));
      if (ev) begin
         chk("bit_cnt_l", 32'(cnt_l), 32'(m_k));
         chk("bit_cnt_m", 32'(cnt_m), 32'(m_k));
      end
   endtask

   task automatic model_update();
      if (!rst) begin
         m_phase = 0;
         m_k     = 0;
         exp_q.delete();
         rx_k    = 0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_word  = D;
                  m_k     = 0;
                  m_phase = 1;
                  exp_q.push_back(D);
               end
            1: if (sout_ready) begin
                  if (m_k == W - 1) m_phase = 2;
                  else              m_k++;
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   // One clock: record the sink's beat, advance model and DUT, then compare.
   task automatic tick();
      logic [W-1:0] exp_w;
      if (rst && valid_l && sout_ready) begin
         rx_l[rx_k]       = sout_l;
         rx_m[W-1-rx_k]   = sout_m;
         rx_k++;
         if (rx_k == W) begin
            rx_k = 0;
            if (exp_q.size() == 0) begin
               chk("rx_unexpected_word", 32'(rx_l), 32'hFFFF_FFFF);
            end else begin
               exp_w = exp_q.pop_front();
               chk("rx_word_lsb", 32'(rx_l), 32'(exp_w));
               chk("rx_word_msb", 32'(rx_m), 32'(exp_w));
            end
         end
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      rst = 1'b1; start = 1'b0; sout_ready = 1'b1; D = '0;
   endtask

   initial begin
      logic [W-1:0] seq_l, seq_m;
      int beats, dones, gap;

      rst = 1'b0; start = 1'b0; sout_ready = 1'b0; D = '0;
      @(negedge clk);
      tick();
      tick();
      chk("reset_state", 32'({sout_l, valid_l, busy_l, done_l, cnt_l}), 32'h0);
      chk("reset_state_dbg", 32'(st_l), 32'h0);

      // LSB-first A5 on one instance, MSB-first on the other, ready held high.
      idle_inputs();
      D = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0; D = 8'h5A;
      for (int i = 0; i < W; i++) begin
         seq_l[i] = sout_l;
         seq_m[i] = sout_m;
         tick();
      end
      chk("a5_lsb_sequence", 32'(seq_l), 32'h0000_00A5);
      chk("a5_msb_sequence", 32'(seq_m), 32'h0000_00A5);
      chk("a5_done_cycle9", 32'({done_l, busy_l}), 32'h2);
      tick();

      // 3C: MSB-first order is 0,0,1,1,1,1,0,0 with bit_cnt 0..7.
      D = 8'h3C; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         seq_m[i] = sout_m;
         chk("3c_bit_cnt_ramp", 32'(cnt_m), 32'(i));
         tick();
      end
      chk("3c_msb_sequence", 32'(seq_m), 32'h0000_003C);
      tick();

      // Backpressure: ready pattern 1,0,0 repeating, count beats to done.
      D = 8'hF0; start = 1'b1;
      tick();
      start = 1'b0;
      beats = 0;
      for (int i = 0; i < 40 && !done_l; i++) begin
         sout_ready = (i % 3 == 0);
         if (valid_l && sout_ready) beats++;
         tick();
      end
      chk("bp_beats", 32'(beats), 32'(W));
      chk("bp_done_seen", 32'(done_l), 32'h1);
      sout_ready = 1'b1;
      tick();

      // Starts during SHIFT and DONE are ignored; the next IDLE start is taken.
      D = 8'h96; start = 1'b1;
      tick();
      dones = 0;
      for (int i = 0; i < W + 1; i++) begin
         D = 8'(i * 37 + 1);
         start = 1'b1;
         tick();
         if (done_l) dones++;
      end
      chk("ignored_start_one_done", 32'(dones), 32'h1);
      // Current cycle is IDLE: this start must be accepted.
      D = 8'h0F; start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_after_done_accepted", 32'(valid_l), 32'h1);
      for (int i = 0; i < W + 1; i++) tick();

      // Back-to-back: start held high, second word begins 2 cycles after last beat.
      D = 8'h01; start = 1'b1;
      tick();
      D = 8'h80;
      for (int i = 0; i < W && !done_l; i++) tick();
      chk("b2b_first_done", 32'(done_l), 32'h1);
      gap = 0;
      for (int i = 0; i < 5 && !valid_l; i++) begin
         tick();
         gap++;
      end
      chk("b2b_gap", 32'(gap), 32'h2);
      start = 1'b0;
      for (int i = 0; i < W + 2; i++) tick();

      // Reset mid-transfer drops the word.
      D = 8'hC3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("midshift_reset", 32'({sout_l, valid_l, busy_l, done_l, cnt_l}), 32'h0);
      chk("midshift_reset_msb", 32'({sout_m, valid_m, busy_m, done_m, cnt_m}), 32'h0);
      rst = 1'b1;
      tick();

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 149) != 0);
         start      = ($urandom_range(0, 2) == 0);
         D          = 8'($urandom);
         sout_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Drain whatever is in flight.
      idle_inputs();
      for (int i = 0; i < W + 4; i++) tick();
      chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
